instr_fetch_mem: RTL and testbench

INSTR_FETCH_MEM -- requirements
Module: instr_fetch_mem

---
 rtl/instr_fetch_mem_pkg.sv | 10 +
 rtl/instr_fetch_mem_ram.sv | 34 +++
 rtl/instr_fetch_mem.sv | 84 ++++++++
 tb/tb_instr_fetch_mem.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_mem_pkg.sv
// Shared defaults and constants for the instruction fetch memory slice.
package instr_fetch_mem_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned DEPTH_DEF  = 256;
  localparam int unsigned ADDR_W_DEF = 32;

  localparam logic [DATA_W_DEF-1:0] NOP_WORD = '0;

endpackage

// File: rtl/instr_fetch_mem_ram.sv
// Simple dual-port instruction RAM: one synchronous write port and one
// synchronous read-first read port with read enable.
module im_ram
  import instr_fetch_mem_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Read and write share one block so a same-address access returns the old word.
  always_ff @(posedge clk_i) begin
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/instr_fetch_mem.sv
// Instruction fetch memory: valid/ready request handshake, range/alignment
// check and a one-deep response register in front of im_ram.
module instr_fetch_mem
  import instr_fetch_mem_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     ReqValid,
  output logic                     ReqReady,
  input  logic [ADDR_W-1:0]        Address,
  output logic                     RspValid,
  input  logic                     RspReady,
  output logic [DATA_W-1:0]        InstructionOut,
  output logic                     RspError,
  input  logic                     Flush,
  input  logic                     LoadEn,
  input  logic [$clog2(DEPTH)-1:0] LoadAddr,
  input  logic [DATA_W-1:0]        LoadData
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic              accept;
  logic              req_err;
  logic [IDX_W-1:0]  req_idx;
  logic [DATA_W-1:0] ram_rdata;

  assign ReqReady = (!rsp_valid_q || RspReady) && !Reset;
  assign accept   = ReqValid && ReqReady && !Flush;
  assign req_idx  = Address[IDX_W+1:2];
  // Upper address bits only feed the range check, so an index never wraps.
  assign req_err  = (Address[1:0] != 2'b00) || ((Address >> 2) >= ADDR_W'(DEPTH));

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    if (Flush) begin
      rsp_valid_d = 1'b0;
      rsp_err_d   = 1'b0;
    end else if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = req_err;
    end else if (RspReady) begin
      rsp_valid_d = 1'b0;
      rsp_err_d   = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  im_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_ram (
    .clk_i   (Clk),
    .we_i    (LoadEn && !Reset),
    .waddr_i (LoadAddr),
    .wdata_i (LoadData),
    .re_i    (accept && !req_err),
    .raddr_i (req_idx),
    .rdata_o (ram_rdata)
  );

  // RAM output holds while stalled because the read port is only enabled on acceptance.
  assign RspValid       = rsp_valid_q;
  assign RspError       = rsp_err_q;
  assign InstructionOut = (rsp_valid_q && !rsp_err_q) ? ram_rdata : DATA_W'(NOP_WORD);

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Directed self-checking bench for instr_fetch_mem with default parameters.
module tb_instr_fetch_mem;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        ReqValid;
  logic        ReqReady;
  logic [31:0] Address;
  logic        RspValid;
  logic        RspReady;
  logic [31:0] InstructionOut;
  logic        RspError;
  logic        Flush;
  logic        LoadEn;
  logic [7:0]  LoadAddr;
  logic [31:0] LoadData;

  int unsigned tests_run = 0;
  int unsigned tests_failed = 0;

  instr_fetch_mem #(
    .DATA_W (32),
    .DEPTH  (256),
    .ADDR_W (32)
  ) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .ReqValid       (ReqValid),
    .ReqReady       (ReqReady),
    .Address        (Address),
    .RspValid       (RspValid),
    .RspReady       (RspReady),
    .InstructionOut (InstructionOut),
    .RspError       (RspError),
    .Flush          (Flush),
    .LoadEn         (LoadEn),
    .LoadAddr       (LoadAddr),
    .LoadData       (LoadData)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic load_word(input logic [7:0] idx, input logic [31:0] val);
    LoadEn = 1'b1; LoadAddr = idx; LoadData = val;
    tick();
    LoadEn = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    tick();
    tick();
    tests_run++;
    if (RspValid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %0b want 0", RspValid); end
    tests_run++;
    if (RspError !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %0b want 0", RspError); end
    tests_run++;
    if (InstructionOut !== 32'h0) begin tests_failed++; $display("FAIL reset_data: got %h want 0", InstructionOut); end
    ReqValid = 1'b1; RspReady = 1'b1; #1;
    tests_run++;
    if (ReqReady !== 1'b0) begin tests_failed++; $display("FAIL reset_reqready: got %0b want 0", ReqReady); end
    ReqValid = 1'b0;
    Reset = 1'b0;
    tick();
    tests_run++;
    if (RspValid !== 1'b0) begin tests_failed++; $display("FAIL reset_no_accept: got %0b want 0", RspValid); end
  endtask

  task automatic test_basic_fetch();
    ReqValid = 1'b1; Address = 32'h0000_000C; RspReady = 1'b1;
    tick();
    ReqValid = 1'b0;
    tests_run++;
    if (RspValid !== 1'b1) begin tests_failed++; $display("FAIL basic_valid: got %0b want 1", RspValid); end
    tests_run++;
    if (InstructionOut !== 32'h2002_0005) begin tests_failed++; $display("FAIL basic_data: got %h want 20020005", InstructionOut); end
    tests_run++;
    if (RspError !== 1'b0) begin tests_failed++; $display("FAIL basic_err: got %0b want 0", RspError); end
    tick();
    tests_run++;
    if (RspValid !== 1'b0) begin tests_failed++; $display("FAIL basic_consumed: got %0b want 0", RspValid); end
    ReqValid = 1'b1; Address = 32'h0000_03FC;
    tick();
    ReqValid = 1'b0;
    tests_run++;
    if (InstructionOut !== 32'hDEAD_BEEF || RspError !== 1'b0)
      begin tests_failed++; $display("FAIL last_word: got %h/%0b want deadbeef/0", InstructionOut, RspError); end
    tick();
  endtask

  task automatic test_errors();
    logic [31:0] bad_addr [3];
    bad_addr[0] = 32'h0000_000E;
    bad_addr[1] = 32'h0000_0400;
    bad_addr[2] = 32'h1000_000C;
    for (int i = 0; i < 3; i++) begin
      ReqValid = 1'b1; Address = bad_addr[i]; RspReady = 1'b1;
      tick();
      ReqValid = 1'b0;
      tests_run++;
      if (RspValid !== 1'b1 || RspError !== 1'b1 || InstructionOut !== 32'h0)
        begin tests_failed++; $display("FAIL err_%0d: got v=%0b e=%0b d=%h want v=1 e=1 d=0", i, RspValid, RspError, InstructionOut); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    RspReady = 1'b1;
    ReqValid = 1'b1; Address = 32'h0;
    tick();
    Address = 32'h4; #1;
    tests_run++;
    if (InstructionOut !== 32'h1000_0000 || ReqReady !== 1'b1)
      begin tests_failed++; $display("FAIL b2b_w0: got %h rdy=%0b want 10000000 rdy=1", InstructionOut, ReqReady); end
    tick();
    Address = 32'h8; RspReady = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      tests_run++;
      if (ReqReady !== 1'b0 || RspValid !== 1'b1 || InstructionOut !== 32'h1000_0001)
        begin tests_failed++; $display("FAIL b2b_stall_%0d: got rdy=%0b v=%0b d=%h want rdy=0 v=1 d=10000001", c, ReqReady, RspValid, InstructionOut); end
      tick();
    end
    RspReady = 1'b1; #1;
    tests_run++;
    if (ReqReady !== 1'b1 || InstructionOut !== 32'h1000_0001)
      begin tests_failed++; $display("FAIL b2b_release: got rdy=%0b d=%h want rdy=1 d=10000001", ReqReady, InstructionOut); end
    tick();
    ReqValid = 1'b0;
    tests_run++;
    if (RspValid !== 1'b1 || InstructionOut !== 32'h1000_0002)
      begin tests_failed++; $display("FAIL b2b_w2: got v=%0b d=%h want v=1 d=10000002", RspValid, InstructionOut); end
    tick();
    tests_run++;
    if (RspValid !== 1'b0) begin tests_failed++; $display("FAIL b2b_drain: got %0b want 0", RspValid); end
  endtask

  task automatic test_read_first();
    LoadEn = 1'b1; LoadAddr = 8'd5; LoadData = 32'hAAAA_AAAA;
    ReqValid = 1'b1; Address = 32'h14; RspReady = 1'b1;
    tick();
    LoadEn = 1'b0;
    tests_run++;
    if (InstructionOut !== 32'h1111_1111) begin tests_failed++; $display("FAIL read_first_old: got %h want 11111111", InstructionOut); end
    tick();
    ReqValid = 1'b0;
    tests_run++;
    if (InstructionOut !== 32'hAAAA_AAAA) begin tests_failed++; $display("FAIL read_first_new: got %h want aaaaaaaa", InstructionOut); end
    tick();
  endtask

  task automatic test_flush();
    ReqValid = 1'b1; Address = 32'h0; RspReady = 1'b1;
    tick();
    RspReady = 1'b0; Flush = 1'b1; Address = 32'h4;
    LoadEn = 1'b1; LoadAddr = 8'd6; LoadData = 32'h6666_6666;
    tick();
    Flush = 1'b0; ReqValid = 1'b0; LoadEn = 1'b0;
    tests_run++;
    if (RspValid !== 1'b0) begin tests_failed++; $display("FAIL flush_clear: got %0b want 0", RspValid); end
    tick();
    tests_run++;
    if (RspValid !== 1'b0) begin tests_failed++; $display("FAIL flush_drop_req: got %0b want 0", RspValid); end
    RspReady = 1'b1; ReqValid = 1'b1; Address = 32'h18;
    tick();
    ReqValid = 1'b0;
    tests_run++;
    if (InstructionOut !== 32'h6666_6666) begin tests_failed++; $display("FAIL flush_load: got %h want 66666666", InstructionOut); end
    tick();
  endtask

  task automatic test_reset_mid_stall();
    ReqValid = 1'b1; Address = 32'h8; RspReady = 1'b0;
    tick();
    ReqValid = 1'b0;
    tick();
    tests_run++;
    if (RspValid !== 1'b1 || InstructionOut !== 32'h1000_0002)
      begin tests_failed++; $display("FAIL stall_hold: got v=%0b d=%h want v=1 d=10000002", RspValid, InstructionOut); end
    Reset = 1'b1; LoadEn = 1'b1; LoadAddr = 8'd3; LoadData = 32'hFFFF_FFFF;
    tick();
    Reset = 1'b0; LoadEn = 1'b0;
    tests_run++;
    if (RspValid !== 1'b0 || RspError !== 1'b0 || InstructionOut !== 32'h0)
      begin tests_failed++; $display("FAIL stall_reset: got v=%0b e=%0b d=%h want all 0", RspValid, RspError, InstructionOut); end
    RspReady = 1'b1; ReqValid = 1'b1; Address = 32'hC;
    tick();
    ReqValid = 1'b0;
    tests_run++;
    if (InstructionOut !== 32'h2002_0005) begin tests_failed++; $display("FAIL mem_retained: got %h want 20020005", InstructionOut); end
    tick();
  endtask

  initial begin
    Reset = 1'b1; ReqValid = 1'b0; Address = '0; RspReady = 1'b0;
    Flush = 1'b0; LoadEn = 1'b0; LoadAddr = '0; LoadData = '0;
    test_reset();
    load_word(8'd0, 32'h1000_0000);
    load_word(8'd1, 32'h1000_0001);
    load_word(8'd2, 32'h1000_0002);
    load_word(8'd3, 32'h2002_0005);
    load_word(8'd5, 32'h1111_1111);
    load_word(8'd255, 32'hDEAD_BEEF);
    test_basic_fetch();
    test_errors();
    test_back_to_back();
    test_read_first();
    test_flush();
    test_reset_mid_stall();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
